wb_port_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file (`a3`/`we3`/`wd`) among several writeback requesters, such as the ALU pipe, LSU and mul/div unit. It arbitrates round-robin, registers the winning write onto the port, and keeps a per-register busy scoreboard so the issue stage can detect RAW and WAW hazards. It sits between the execution units and `reg_file` and sequences every architectural register write.

---
 rtl/wb_port_arbiter.sv | 107 ++++++++++
 tb/tb_wb_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin writeback port arbiter with register busy scoreboard
module wb_port_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*5-1:0]    req_addr,
   input  logic [NREQ*XLEN-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 wb_we,
   output logic [4:0]           wb_addr,
   output logic [XLEN-1:0]      wb_data,
   input  logic                 iss_valid,
   input  logic [4:0]           iss_rd,
   output logic                 iss_ready,
   input  logic [4:0]           q_rs1,
   input  logic [4:0]           q_rs2,
   output logic                 q_busy1,
   output logic                 q_busy2
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [31:0]     busy_q, busy_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic            wb_we_q, wb_we_d;
   logic [4:0]      wb_addr_q, wb_addr_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;

   logic            gnt_any;
   logic [PW-1:0]   gnt_idx;
   logic [4:0]      win_addr;
   logic [XLEN-1:0] win_data;
   logic            iss_fire;

   // Search starts at ptr and wraps; the first valid requester wins.
   always_comb begin : arb
      int idx;
      idx       = 0;
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      win_addr  = '0;
      win_data  = '0;
      req_ready = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!gnt_any && req_valid[idx]) begin
            gnt_any        = 1'b1;
            gnt_idx        = PW'(idx);
            win_addr       = req_addr[idx*5 +: 5];
            win_data       = req_data[idx*XLEN +: XLEN];
            req_ready[idx] = 1'b1;
         end
      end
   end

   assign iss_ready = (iss_rd == 5'd0) || !busy_q[iss_rd];
   assign iss_fire  = iss_valid && iss_ready && (iss_rd != 5'd0);

   always_comb begin
      ptr_d     = ptr_q;
      wb_we_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      if (gnt_any) begin
         ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         if (win_addr != 5'd0) begin
            wb_we_d   = 1'b1;
            wb_addr_d = win_addr;
            wb_data_d = win_data;
         end
      end
   end

   // Commit clear is applied before allocation so a same-edge collision ends set.
   always_comb begin
      busy_d = busy_q;
      if (wb_we_q) busy_d[wb_addr_q] = 1'b0;
      if (iss_fire) busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q    <= '0;
         ptr_q     <= '0;
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         busy_q    <= busy_d;
         ptr_q     <= ptr_d;
         wb_we_q   <= wb_we_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign wb_we   = wb_we_q;
   assign wb_addr = wb_addr_q;
   assign wb_data = wb_data_q;
   assign q_busy1 = (q_rs1 != 5'd0) && busy_q[q_rs1];
   assign q_busy2 = (q_rs2 != 5'd0) && busy_q[q_rs2];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
   localparam int NREQ = 3;
   localparam int XLEN = 32;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*5-1:0]    req_addr;
   logic [NREQ*XLEN-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 wb_we;
   logic [4:0]           wb_addr;
   logic [XLEN-1:0]      wb_data;
   logic                 iss_valid;
   logic [4:0]           iss_rd;
   logic                 iss_ready;
   logic [4:0]           q_rs1;
   logic [4:0]           q_rs2;
   logic                 q_busy1;
   logic                 q_busy2;

   wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wb_we     (wb_we),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_ready (iss_ready),
      .q_rs1     (q_rs1),
      .q_rs2     (q_rs2),
      .q_busy1   (q_busy1),
      .q_busy2   (q_busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_t;

   wb_t         sb[$];
   int          checks = 0;
   int          failures = 0;
   int          m_ptr = 0;
   logic [31:0] m_busy = '0;
   logic        m_we = 1'b0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_busy = '0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      sb.delete();
   endtask

   // Entered and left at posedge+1: drive, check combinational outputs, predict, clock, compare.
   task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                       input logic iv, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      int          g;
      logic [2:0]  er;
      logic        exp_iss;
      logic [31:0] nb;
      wb_t         e;
      wb_t         x;
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      iss_valid = iv;
      iss_rd    = rd;
      q_rs1     = rs1;
      q_rs2     = rs2;
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++)
         if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      exp_iss = (rd == 5'd0) || !m_busy[rd];
      chk("iss_ready", 32'(iss_ready), 32'(exp_iss));
      chk("q_busy1", 32'(q_busy1), 32'((rs1 != 5'd0) && m_busy[rs1]));
      chk("q_busy2", 32'(q_busy2), 32'((rs2 != 5'd0) && m_busy[rs2]));
      e.we   = 1'b0;
      e.addr = m_addr;
      e.data = m_data;
      if (g >= 0) begin
         m_ptr = (g + 1) % NREQ;
         if (a[g*5 +: 5] != 5'd0) begin
            e.we   = 1'b1;
            e.addr = a[g*5 +: 5];
            e.data = d[g*32 +: 32];
         end
      end
      sb.push_back(e);
      nb = m_busy;
      if (m_we) nb[m_addr] = 1'b0;
      if (iv && exp_iss && rd != 5'd0) nb[rd] = 1'b1;
      @(posedge clk);
      #1;
      m_busy = nb;
      x = sb.pop_front();
      chk("wb_we", 32'(wb_we), 32'(x.we));
      chk("wb_addr", 32'(wb_addr), 32'(x.addr));
      chk("wb_data", wb_data, x.data);
      m_we   = x.we;
      m_addr = x.addr;
      m_data = x.data;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      iss_valid = 1'b0;
      iss_rd    = '0;
      q_rs1     = 5'd5;
      q_rs2     = 5'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_wb_we", 32'(wb_we), 32'd0);
      chk("rst_wb_addr", 32'(wb_addr), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_iss_ready", 32'(iss_ready), 32'd1);
      chk("rst_q_busy1", 32'(q_busy1), 32'd0);
      rst = 1'b0;

      // allocate x5, then single write from req0
      step(3'b000, 15'd0, 96'd0, 1'b1, 5'd5, 5'd5, 5'd0);
      step(3'b001, {5'd0, 5'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 1'b0, 5'd0, 5'd5, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd5, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd5, 5'd0);

      // sustained requests from all three
      for (int i = 0; i < 6; i++)
         step(3'b111, {5'd12, 5'd11, 5'd10},
              {32'hC000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)},
              1'b0, 5'd0, 5'd10, 5'd11);

      // x0 write is consumed without a port write
      step(3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'h1234_5678, 32'd0}, 1'b1, 5'd0, 5'd0, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd0, 5'd0);

      // WAW refusal until commit
      step(3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd7, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd7, 5'd0);
      step(3'b100, {5'd7, 5'd0, 5'd0}, {32'h7777_0001, 64'd0}, 1'b1, 5'd7, 5'd7, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd7, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd7, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd7, 5'd0);

      // drain x7, then allocate x7 in the cycle its unrequested write commits
      step(3'b001, {5'd0, 5'd0, 5'd7}, {64'd0, 32'h7777_0002}, 1'b0, 5'd0, 5'd7, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd7, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd7, 5'd0);
      step(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'h7777_0003, 32'd0}, 1'b0, 5'd0, 5'd7, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b1, 5'd7, 5'd7, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd7, 5'd0);

      // asynchronous reset with a write in flight
      step(3'b000, 15'd0, 96'd0, 1'b1, 5'd3, 5'd3, 5'd7);
      step(3'b001, {5'd0, 5'd0, 5'd3}, {64'd0, 32'h3333_3333}, 1'b0, 5'd0, 5'd3, 5'd7);
      req_valid = '0;
      iss_valid = 1'b0;
      iss_rd    = 5'd3;
      #2;
      chk("pre_rst_wb_we", 32'(wb_we), 32'd1);
      chk("pre_rst_q_busy1", 32'(q_busy1), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_wb_we", 32'(wb_we), 32'd0);
      chk("async_rst_wb_addr", 32'(wb_addr), 32'd0);
      chk("async_rst_q_busy1", 32'(q_busy1), 32'd0);
      chk("async_rst_q_busy2", 32'(q_busy2), 32'd0);
      chk("async_rst_iss_ready", 32'(iss_ready), 32'd1);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd3, 5'd7);
      step(3'b111, {5'd22, 5'd21, 5'd20}, {32'hCC, 32'hBB, 32'hAA}, 1'b0, 5'd0, 5'd3, 5'd0);
      step(3'b111, {5'd22, 5'd21, 5'd20}, {32'hCC, 32'hBB, 32'hAA}, 1'b0, 5'd0, 5'd3, 5'd0);
      step(3'b000, 15'd0, 96'd0, 1'b0, 5'd0, 5'd3, 5'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
